// File: rtl/parity_rr_sched.sv
// Round-robin arbiter sharing one parity stage among NUM_REQ requesters.
// Ports: cfg_req_en/cfg_err_inject config, req_valid/req_data/req_ready
// requester side, out_valid/out_ready/out_data/out_id output side,
// frame_cnt = words accepted into the output register.
module parity_rr_sched #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2,
  parameter bit          PARITY_TYPE = 1'b0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            cfg_req_en,
  input  logic                          cfg_err_inject,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH:0]           out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [15:0]                   frame_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_WIDTH:0] data_q, data_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    elig;
  logic                  load;
  logic                  found;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  par;

  assign elig = req_valid & cfg_req_en;
  assign load = (state_q == EMPTY) | out_ready;

  // Search starts just after the last winner and wraps.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(last_q) + k) % int'(NUM_REQ);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_WIDTH'(idx);
      end
    end
  end

  assign sel_data = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign par      = (^sel_data) ^ ~PARITY_TYPE ^ cfg_err_inject;

  always_comb begin
    req_ready = '0;
    if (rstn && load && found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (load) begin
      if (found) begin
        state_d = FULL;
        data_d  = {par, sel_data};
        id_d    = gnt_idx;
        last_d  = gnt_idx;
        cnt_d   = cnt_q + 16'd1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_parity_rr_sched.sv
// Randomised scoreboard bench for parity_rr_sched.
// Driver runs a reference model; monitor pops on every drained word.
module tb_parity_rr_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam bit PT = 1'b0;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    cfg_req_en = '0;
  logic            cfg_err_inject = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW:0]     out_data;
  logic [IW-1:0]   out_id;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  parity_rr_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(N),
    .ID_WIDTH(IW), .PARITY_TYPE(PT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_req_en(cfg_req_en),
    .cfg_err_inject(cfg_err_inject),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_id(out_id),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [DW:0]   data;
    logic [IW-1:0] id;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_last = N - 1;
  bit   m_valid = 1'b0;
  int   m_cnt = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Parity bit chosen so the 9-bit word has the required
  // count of ones, then flipped in link-test mode.
  function automatic bit par_of(logic [DW-1:0] d, bit inj);
    int tgt;
    bit p;
    tgt = PT ? 0 : 1;
    p   = ((($countones(d) + tgt) % 2) == 1);
    return p ^ inj;
  endfunction

  task automatic step(bit rs, logic [N-1:0] en,
                      logic [N-1:0] vl, logic [N*DW-1:0] dt,
                      bit ordy, bit inj);
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    logic [DW-1:0] d;
    bit load;
    int g;
    exp_t e;
    @(negedge clk);
    rstn = rs;
    cfg_req_en = en;
    req_valid = vl;
    req_data = dt;
    out_ready = ordy;
    cfg_err_inject = inj;
    #1;
    elig = vl & en;
    load = !m_valid || ordy;
    g = -1;
    if (rs && load) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && elig[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    @(posedge clk);
    if (!rs) begin
      m_valid = 1'b0;
      m_last = N - 1;
      m_cnt = 0;
      sb.delete();
    end else if (load) begin
      if (g >= 0) begin
        d = dt[g*DW +: DW];
        m_cnt = (m_cnt + 1) % 65536;
        e.data = {par_of(d, inj), d};
        e.id = IW'(g);
        e.cnt = 16'(m_cnt);
        sb.push_back(e);
        m_valid = 1'b1;
        m_last = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Monitor: a word leaves when out_valid & out_ready at an edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got word %0h expected none",
                   out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_id", 32'(out_id), 32'(e.id));
          chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    logic [DW:0] held_d;
    logic [IW-1:0] held_i;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);

    // Single requester 2 with 8'h07.
    step(1, 4'hF, 4'b0100, 32'h0007_0000, 1, 0);
    #1;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h007);
    chk("t1_id", 32'(out_id), 32'd2);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);

    // All requesters, full throughput.
    repeat (8) step(1, 4'hF, 4'hF, rnd_data(), 1, 0);

    // Backpressure hold.
    step(1, 4'hF, 4'hF, rnd_data(), 0, 0);
    #1;
    held_d = out_data;
    held_i = out_id;
    repeat (5) step(1, 4'hF, 4'hF, rnd_data(), 0, 0);
    #1;
    chk("hold_data", 32'(out_data), 32'(held_d));
    chk("hold_id", 32'(out_id), 32'(held_i));
    step(1, 4'hF, 4'hF, rnd_data(), 1, 0);

    // Masked requesters 0 and 2.
    repeat (6) step(1, 4'b1010, 4'hF, rnd_data(), 1, 0);

    // Parity of zero data, inject and normal.
    step(1, 4'hF, 4'b0001, '0, 1, 1);
    #1;
    chk("inj_data", 32'(out_data), 32'h000);
    step(1, 4'hF, 4'b0001, '0, 1, 0);
    #1;
    chk("par_data", 32'(out_data), 32'h100);

    // Reset while a word is held.
    step(1, 4'hF, 4'hF, rnd_data(), 0, 0);
    step(0, 4'hF, 4'hF, rnd_data(), 0, 0);
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_cnt", 32'(frame_cnt), 32'd0);
    step(1, 4'hF, 4'hF, rnd_data(), 1, 0);
    #1;
    chk("mrst_id", 32'(out_id), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0),
           ($urandom_range(3) == 0) ? N'($urandom) : 4'hF,
           N'($urandom), rnd_data(),
           ($urandom_range(9) < 7), ($urandom_range(7) == 0));
    end

    // Counter wrap.
    step(0, 4'hF, 4'h0, '0, 1, 0);
    repeat (65535) step(1, 4'h1, 4'h1, rnd_data(), 1, 0);
    #1;
    chk("cnt_max", 32'(frame_cnt), 32'hFFFF);
    step(1, 4'h1, 4'h1, rnd_data(), 1, 0);
    #1;
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);

    // Drain.
    repeat (2) step(1, 4'hF, 4'h0, '0, 1, 0);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
